// File: rtl/pc_seq_unit.sv
// Fetch-stage program counter: conditional branch evaluation, stall/halt handling, redirect pulse.
// Optional taken/not-taken branch counters are enabled by defining PC_BRANCH_STATS_EN.
module pc_seq_unit #(
  parameter int              PC_W     = 16,
  parameter int              IMM_W    = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic [1:0]       bsig_i,
  input  logic [2:0]       cond_i,
  input  logic [2:0]       flags_i,
  input  logic [IMM_W-1:0] imm_i,
  input  logic [PC_W-1:0]  regsrc_i,
  output logic [PC_W-1:0]  pc_o,
  output logic [PC_W-1:0]  pc_plus2_o,
  output logic             redirect_o,
`ifdef PC_BRANCH_STATS_EN
  output logic [15:0]      br_taken_cnt_o,
  output logic [15:0]      br_ntaken_cnt_o,
`endif
  output logic             halted_o
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  localparam logic [1:0] BS_SEQ = 2'b00;
  localparam logic [1:0] BS_B   = 2'b01;
  localparam logic [1:0] BS_BR  = 2'b10;
  localparam logic [1:0] BS_HLT = 2'b11;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            redirect_q, redirect_d;

  logic            flag_n, flag_v, flag_z;
  logic            truth;
  logic [PC_W-1:0] pc_plus2;
  logic [PC_W-1:0] imm_sx;
  logic [PC_W-1:0] b_target;
  logic [PC_W-1:0] br_target;
  logic            accept;

  assign flag_n = flags_i[2];
  assign flag_v = flags_i[1];
  assign flag_z = flags_i[0];

  always_comb begin
    truth = 1'b0;
    case (cond_i)
      3'b000:  truth = ~flag_z;
      3'b001:  truth = flag_z;
      3'b010:  truth = ~flag_z & ~flag_n;
      3'b011:  truth = flag_n;
      3'b100:  truth = flag_z | (~flag_z & ~flag_n);
      3'b101:  truth = flag_n | flag_z;
      3'b110:  truth = flag_v;
      default: truth = 1'b1;
    endcase
  end

  // Immediate is a signed word offset; shifting by one converts it to bytes.
  assign pc_plus2  = pc_q + PC_W'(2);
  assign imm_sx    = PC_W'($signed(imm_i));
  assign b_target  = pc_plus2 + (imm_sx << 1);
  assign br_target = regsrc_i & ~PC_W'(1);
  assign accept    = (state_q == ST_RUN) && !stall_i;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = 1'b0;
    if (accept) begin
      case (bsig_i)
        BS_SEQ: pc_d = pc_plus2;
        BS_B: begin
          pc_d       = truth ? b_target : pc_plus2;
          redirect_d = truth;
        end
        BS_BR: begin
          pc_d       = truth ? br_target : pc_plus2;
          redirect_d = truth;
        end
        BS_HLT:  state_d = ST_HALTED;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_plus2_o = pc_plus2;
  assign redirect_o = redirect_q;
  assign halted_o   = (state_q == ST_HALTED);

`ifdef PC_BRANCH_STATS_EN
  logic        is_branch;
  logic [15:0] tk_cnt_q, tk_cnt_d;
  logic [15:0] nt_cnt_q, nt_cnt_d;

  assign is_branch = accept && ((bsig_i == BS_B) || (bsig_i == BS_BR));

  always_comb begin
    tk_cnt_d = tk_cnt_q;
    nt_cnt_d = nt_cnt_q;
    if (is_branch && truth && (tk_cnt_q != 16'hFFFF))
      tk_cnt_d = tk_cnt_q + 16'd1;
    if (is_branch && !truth && (nt_cnt_q != 16'hFFFF))
      nt_cnt_d = nt_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tk_cnt_q <= 16'd0;
      nt_cnt_q <= 16'd0;
    end else begin
      tk_cnt_q <= tk_cnt_d;
      nt_cnt_q <= nt_cnt_d;
    end
  end

  assign br_taken_cnt_o  = tk_cnt_q;
  assign br_ntaken_cnt_o = nt_cnt_q;
`endif

endmodule

// File: tb/tb_pc_seq_unit.sv
// Self-checking bench for pc_seq_unit: directed scenarios plus randomized run against a reference model.
module tb_pc_seq_unit;

  logic        clk = 1'b0;
  logic        rst, stall;
  logic [1:0]  bsig;
  logic [2:0]  cond, flags;
  logic [8:0]  imm;
  logic [15:0] regsrc;
  logic [15:0] pc, pc_plus2;
  logic        redirect, halted;
`ifdef PC_BRANCH_STATS_EN
  logic [15:0] tk_cnt, nt_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int m_pc;
  bit m_red, m_halt;
  int m_tk, m_nt;

  pc_seq_unit #(.PC_W(16), .IMM_W(9), .RESET_PC(16'h0000)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .bsig_i(bsig), .cond_i(cond),
    .flags_i(flags), .imm_i(imm), .regsrc_i(regsrc),
    .pc_o(pc), .pc_plus2_o(pc_plus2), .redirect_o(redirect),
`ifdef PC_BRANCH_STATS_EN
    .br_taken_cnt_o(tk_cnt), .br_ntaken_cnt_o(nt_cnt),
`endif
    .halted_o(halted)
  );

  always #5 clk = ~clk;

  function automatic bit cond_true(input logic [2:0] c, input logic [2:0] f);
    bit n, v, z;
    n = f[2]; v = f[1]; z = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  // One clock: apply inputs, advance model, sample #1 after the edge.
  task automatic drive(input logic r, input logic s, input logic [1:0] b, input logic [2:0] c,
                       input logic [2:0] f, input logic [8:0] im, input logic [15:0] rs);
    int off;
    bit t;
    rst = r; stall = s; bsig = b; cond = c; flags = f; imm = im; regsrc = rs;
    t = cond_true(c, f);
    off = im[8] ? (int'(im) - 512) : int'(im);
    if (r) begin
      m_pc = 0; m_red = 0; m_halt = 0; m_tk = 0; m_nt = 0;
    end else if (m_halt || s) begin
      m_red = 0;
    end else begin
      m_red = 0;
      case (b)
        2'd0: m_pc = (m_pc + 2) % 65536;
        2'd1, 2'd2: begin
          if (t) begin
            m_pc = (b == 2'd1) ? ((m_pc + 2 + off * 2 + 65536 * 4) % 65536) : (int'(rs) / 2) * 2;
            m_red = 1;
            if (m_tk < 65535) m_tk++;
          end else begin
            m_pc = (m_pc + 2) % 65536;
            if (m_nt < 65535) m_nt++;
          end
        end
        default: m_halt = 1;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive(1, 0, 2'd0, 3'd0, 3'd0, 9'd0, 16'd0);
    drive(1, 1, 2'd3, 3'd7, 3'd0, 9'd0, 16'd0);
    n_cmp++; if (pc !== 16'h0000) begin n_bad++; $display("FAIL reset_pc got=%h exp=0000", pc); end
    n_cmp++; if (redirect !== 1'b0) begin n_bad++; $display("FAIL reset_redirect got=%b exp=0", redirect); end
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
  endtask

  task automatic test_sequential;
    for (int i = 1; i <= 3; i++) begin
      drive(0, 0, 2'd0, 3'd0, 3'd0, 9'd0, 16'd0);
      n_cmp++; if (pc !== 16'(2 * i)) begin n_bad++; $display("FAIL seq_pc step=%0d got=%h exp=%h", i, pc, 16'(2 * i)); end
      n_cmp++; if (redirect !== 1'b0) begin n_bad++; $display("FAIL seq_redirect step=%0d got=%b exp=0", i, redirect); end
    end
  endtask

  task automatic test_branch;
    drive(0, 0, 2'd2, 3'd7, 3'd0, 9'd0, 16'h0010);
    n_cmp++; if (pc !== 16'h0010 || redirect !== 1'b1) begin n_bad++; $display("FAIL br_to_10 got pc=%h red=%b exp pc=0010 red=1", pc, redirect); end
    drive(0, 0, 2'd1, 3'd4, 3'b000, 9'd2, 16'h0000);
    n_cmp++; if (pc !== 16'h0016 || redirect !== 1'b1) begin n_bad++; $display("FAIL b_taken got pc=%h red=%b exp pc=0016 red=1", pc, redirect); end
    drive(0, 0, 2'd0, 3'd0, 3'd0, 9'd0, 16'h0000);
    n_cmp++; if (pc !== 16'h0018 || redirect !== 1'b0) begin n_bad++; $display("FAIL redirect_one_cycle got pc=%h red=%b exp pc=0018 red=0", pc, redirect); end
    drive(0, 0, 2'd2, 3'd7, 3'd0, 9'd0, 16'h0010);
    drive(0, 0, 2'd1, 3'd4, 3'b100, 9'd2, 16'h0000);
    n_cmp++; if (pc !== 16'h0012 || redirect !== 1'b0) begin n_bad++; $display("FAIL b_not_taken got pc=%h red=%b exp pc=0012 red=0", pc, redirect); end
    // negative offset: imm=-3 words from 0x12 -> 0x14-6 = 0x0E
    drive(0, 0, 2'd1, 3'd7, 3'b000, 9'h1FD, 16'h0000);
    n_cmp++; if (pc !== 16'h000E) begin n_bad++; $display("FAIL b_negative got pc=%h exp=000e", pc); end
  endtask

  task automatic test_wrap;
    drive(0, 0, 2'd2, 3'd7, 3'd0, 9'd0, 16'hFFFF);
    n_cmp++; if (pc !== 16'hFFFE || redirect !== 1'b1) begin n_bad++; $display("FAIL br_bit0_clear got pc=%h red=%b exp pc=fffe red=1", pc, redirect); end
    n_cmp++; if (pc_plus2 !== 16'h0000) begin n_bad++; $display("FAIL pc_plus2_wrap got=%h exp=0000", pc_plus2); end
    drive(0, 0, 2'd0, 3'd0, 3'd0, 9'd0, 16'h0000);
    n_cmp++; if (pc !== 16'h0000) begin n_bad++; $display("FAIL seq_wrap got=%h exp=0000", pc); end
  endtask

  task automatic test_stall;
    drive(0, 0, 2'd2, 3'd7, 3'd0, 9'd0, 16'h0040);
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 2'd1, 3'd7, 3'd0, 9'd4, 16'h0000);
      n_cmp++; if (pc !== 16'h0040 || redirect !== 1'b0) begin n_bad++; $display("FAIL stall_hold got pc=%h red=%b exp pc=0040 red=0", pc, redirect); end
    end
    drive(0, 1, 2'd3, 3'd0, 3'd0, 9'd0, 16'h0000);
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL stall_hlt_ignored got=%b exp=0", halted); end
    drive(0, 0, 2'd1, 3'd7, 3'd0, 9'd4, 16'h0000);
    n_cmp++; if (pc !== 16'h004A || redirect !== 1'b1) begin n_bad++; $display("FAIL stall_release got pc=%h red=%b exp pc=004a red=1", pc, redirect); end
  endtask

  task automatic test_back_to_back;
    drive(0, 0, 2'd1, 3'd7, 3'd0, 9'd0, 16'h0000);
    n_cmp++; if (pc !== 16'h004C || redirect !== 1'b1) begin n_bad++; $display("FAIL b2b_first got pc=%h red=%b exp pc=004c red=1", pc, redirect); end
    drive(0, 0, 2'd2, 3'd1, 3'b001, 9'd0, 16'h0100);
    n_cmp++; if (pc !== 16'h0100 || redirect !== 1'b1) begin n_bad++; $display("FAIL b2b_second got pc=%h red=%b exp pc=0100 red=1", pc, redirect); end
  endtask

  task automatic test_halt;
    drive(0, 0, 2'd2, 3'd7, 3'd0, 9'd0, 16'h0020);
    drive(0, 0, 2'd3, 3'd0, 3'd0, 9'd0, 16'h0000);
    n_cmp++; if (pc !== 16'h0020 || halted !== 1'b1 || redirect !== 1'b0) begin n_bad++; $display("FAIL hlt_enter got pc=%h halted=%b red=%b exp 0020/1/0", pc, halted, redirect); end
    for (int i = 0; i < 5; i++) begin
      drive(0, i[0], 2'd1, 3'd7, 3'd0, 9'd5, 16'h0000);
      n_cmp++; if (pc !== 16'h0020 || halted !== 1'b1 || redirect !== 1'b0) begin n_bad++; $display("FAIL hlt_frozen cyc=%0d got pc=%h halted=%b red=%b", i, pc, halted, redirect); end
    end
    drive(1, 0, 2'd1, 3'd7, 3'd0, 9'd0, 16'h0000);
    n_cmp++; if (pc !== 16'h0000 || halted !== 1'b0) begin n_bad++; $display("FAIL hlt_reset got pc=%h halted=%b exp 0000/0", pc, halted); end
  endtask

`ifdef PC_BRANCH_STATS_EN
  task automatic test_stats;
    drive(1, 0, 2'd0, 3'd0, 3'd0, 9'd0, 16'h0000);
    drive(0, 0, 2'd1, 3'd7, 3'd0, 9'd1, 16'h0000);
    drive(0, 0, 2'd1, 3'd0, 3'b001, 9'd1, 16'h0000);
    drive(0, 1, 2'd1, 3'd7, 3'd0, 9'd1, 16'h0000);
    drive(0, 0, 2'd2, 3'd6, 3'b010, 9'd0, 16'h0080);
    drive(0, 0, 2'd2, 3'd3, 3'b000, 9'd0, 16'h0080);
    drive(0, 0, 2'd1, 3'd5, 3'b100, 9'd3, 16'h0000);
    n_cmp++; if (tk_cnt !== 16'd3) begin n_bad++; $display("FAIL stats_taken got=%0d exp=3", tk_cnt); end
    n_cmp++; if (nt_cnt !== 16'd2) begin n_bad++; $display("FAIL stats_ntaken got=%0d exp=2", nt_cnt); end
  endtask
`endif

  task automatic test_random;
    logic       r, s;
    logic [1:0] b;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 49) == 0);
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 29) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if (m_halt && $urandom_range(0, 5) == 0) r = 1'b1;
      drive(r, s, b, 3'($urandom), 3'($urandom), 9'($urandom), 16'($urandom));
      n_cmp++;
      if (pc !== 16'(m_pc) || redirect !== m_red || halted !== m_halt || pc_plus2 !== 16'(m_pc + 2)) begin
        n_bad++;
        $display("FAIL rand cyc=%0d got pc=%h p2=%h red=%b hlt=%b exp pc=%h red=%b hlt=%b",
                 i, pc, pc_plus2, redirect, halted, 16'(m_pc), m_red, m_halt);
      end
`ifdef PC_BRANCH_STATS_EN
      n_cmp++;
      if (tk_cnt !== 16'(m_tk) || nt_cnt !== 16'(m_nt)) begin
        n_bad++;
        $display("FAIL rand_stats cyc=%0d got tk=%0d nt=%0d exp tk=%0d nt=%0d", i, tk_cnt, nt_cnt, m_tk, m_nt);
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; bsig = 2'd0; cond = 3'd0; flags = 3'd0; imm = 9'd0; regsrc = 16'd0;
    m_pc = 0; m_red = 0; m_halt = 0; m_tk = 0; m_nt = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_wrap();
    test_stall();
    test_back_to_back();
    test_halt();
`ifdef PC_BRANCH_STATS_EN
    test_stats();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
